// File: rtl/obj_sched_pkg.sv
// Shared constants and types for the object frame scheduler.
package obj_sched_pkg;

   localparam int unsigned DEF_NUM_OBJ     = 6;
   localparam int unsigned DEF_LOC_W       = 21;
   localparam int unsigned DEF_TICK_PERIOD = 10000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef logic [DEF_LOC_W-1:0] loc_t;

endpackage

// File: rtl/obj_frame_sched_if.sv
// Valid/ready stream of snapshot object locations tagged with object index.
interface obj_frame_sched_if
   import obj_sched_pkg::*;
#(
   parameter int unsigned LOC_W = DEF_LOC_W,
   parameter int unsigned IDX_W = $clog2(DEF_NUM_OBJ)
) ();

   logic             obj_valid_out;
   logic             obj_ready_in;
   logic [LOC_W-1:0] obj_loc_out;
   logic [IDX_W-1:0] obj_idx_out;

   modport master (
      output obj_valid_out,
      output obj_loc_out,
      output obj_idx_out,
      input  obj_ready_in
   );

   modport slave (
      input  obj_valid_out,
      input  obj_loc_out,
      input  obj_idx_out,
      output obj_ready_in
   );

endinterface

// File: rtl/frame_tick_gen.sv
// Free-running period counter; emits a one-cycle tick at the end of each period while enabled.
module frame_tick_gen
   import obj_sched_pkg::*;
#(
   parameter int unsigned PERIOD = DEF_TICK_PERIOD
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic enable_in,
   output logic tick_c
);

   localparam int unsigned    CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] cnt;

   // Count 0..PERIOD-1 while enabled; disabling parks the counter at 0 so re-enable starts a full period.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt <= '0;
      end else if (!enable_in || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tick_c = enable_in && (cnt == LAST);

endmodule

// File: rtl/obj_frame_sched.sv
// Frame scheduler: snapshots all object locations on each tick and streams them one per handshake.
module obj_frame_sched
   import obj_sched_pkg::*;
#(
   parameter int unsigned NUM_OBJ     = DEF_NUM_OBJ,
   parameter int unsigned LOC_W       = DEF_LOC_W,
   parameter int unsigned TICK_PERIOD = DEF_TICK_PERIOD,
   parameter int unsigned IDX_W       = $clog2(NUM_OBJ)
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 enable_in,
   input  logic [LOC_W-1:0]     obj_loc_in [NUM_OBJ],
   obj_frame_sched_if.master    obj_bus,
   output logic                 frame_start_out,
   output logic                 frame_done_out,
   output logic                 busy_out,
   output logic [7:0]           overrun_cnt_out
);

   localparam logic [1:0]       ST_IDLE  = 2'(IDLE);
   localparam logic [1:0]       ST_SEND  = 2'(SEND);
   localparam logic [1:0]       ST_DONE  = 2'(DONE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

   logic                 tick_c;
   logic [1:0]           state, state_n;
   logic [IDX_W-1:0]     idx, idx_n;
   logic [LOC_W-1:0]     shadow [NUM_OBJ];
   logic                 load_n;
   logic                 valid_q;
   logic [LOC_W-1:0]     loc_q, loc_n;
   logic [7:0]           overrun_n;

   frame_tick_gen #(
      .PERIOD (TICK_PERIOD)
   ) u_tick (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .enable_in (enable_in),
      .tick_c    (tick_c)
   );

   // Next-state, next-index and registered-output values.
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      load_n    = 1'b0;
      overrun_n = overrun_cnt_out;
      case (state)
         ST_IDLE: begin
            if (tick_c) begin
               load_n  = 1'b1;
               state_n = ST_SEND;
               idx_n   = '0;
            end
         end
         ST_SEND: begin
            if (obj_bus.obj_ready_in) begin
               if (idx == LAST_IDX) begin
                  state_n = ST_DONE;
               end else begin
                  idx_n = idx + IDX_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
            idx_n   = '0;
         end
         default: begin
            state_n = ST_IDLE;
            idx_n   = '0;
         end
      endcase
      // The snapshot is written this cycle, so the first word comes straight from the live input.
      loc_n = load_n ? obj_loc_in[0] : shadow[idx_n];
      // A tick outside IDLE (including the DONE cycle) is dropped and counted.
      if (tick_c && state != ST_IDLE && overrun_cnt_out != 8'hFF) begin
         overrun_n = overrun_cnt_out + 8'd1;
      end
   end

   // State, index and all registered outputs.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state           <= ST_IDLE;
         idx             <= '0;
         valid_q         <= 1'b0;
         loc_q           <= '0;
         frame_start_out <= 1'b0;
         frame_done_out  <= 1'b0;
         busy_out        <= 1'b0;
         overrun_cnt_out <= '0;
      end else begin
         state           <= state_n;
         idx             <= idx_n;
         valid_q         <= (state_n == ST_SEND);
         loc_q           <= loc_n;
         frame_start_out <= load_n;
         frame_done_out  <= (state_n == ST_DONE);
         busy_out        <= (state_n != ST_IDLE);
         overrun_cnt_out <= overrun_n;
      end
   end

   // Shadow copy of every object location, taken only at frame start.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < int'(NUM_OBJ); i++) begin
            shadow[i] <= '0;
         end
      end else if (load_n) begin
         for (int i = 0; i < int'(NUM_OBJ); i++) begin
            shadow[i] <= obj_loc_in[i];
         end
      end
   end

   assign obj_bus.obj_valid_out = valid_q;
   assign obj_bus.obj_loc_out   = loc_q;
   assign obj_bus.obj_idx_out   = idx;

endmodule

// File: tb/tb_obj_frame_sched.sv
// Directed bench for obj_frame_sched with a short tick period.
module tb_obj_frame_sched;
   import obj_sched_pkg::*;

   localparam int unsigned N  = 6;
   localparam int unsigned LW = 21;
   localparam int unsigned TP = 16;

   logic          clk_in;
   logic          rst_in;
   logic          enable_in;
   logic [LW-1:0] obj_loc [N];
   logic          frame_start_out;
   logic          frame_done_out;
   logic          busy_out;
   logic [7:0]    overrun_cnt_out;

   int errors = 0;
   int checks = 0;

   loc_t old_locs  [N];
   loc_t ones_locs [N];
   loc_t abc_locs  [N];

   obj_frame_sched_if #(.LOC_W(LW), .IDX_W(3)) bus ();

   obj_frame_sched #(
      .NUM_OBJ     (N),
      .LOC_W       (LW),
      .TICK_PERIOD (TP),
      .IDX_W       (3)
   ) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .enable_in       (enable_in),
      .obj_loc_in      (obj_loc),
      .obj_bus         (bus),
      .frame_start_out (frame_start_out),
      .frame_done_out  (frame_done_out),
      .busy_out        (busy_out),
      .overrun_cnt_out (overrun_cnt_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic set_locs(input loc_t v [N]);
      for (int i = 0; i < int'(N); i++) obj_loc[i] = v[i];
   endtask

   // Reset, then enable on the release edge; the frame start is then 16 negedges away.
   task automatic do_reset();
      @(negedge clk_in);
      rst_in = 1'b1;
      enable_in = 1'b0;
      bus.obj_ready_in = 1'b0;
      @(negedge clk_in);
      rst_in = 1'b0;
      enable_in = 1'b1;
   endtask

   task automatic wait_start(input string nm);
      int n = 0;
      while (frame_start_out !== 1'b1 && n < 200) begin
         @(negedge clk_in);
         n++;
      end
      checks++;
      if (frame_start_out !== 1'b1) begin
         errors++;
         $display("FAIL %s wait_start: frame_start_out=%b after %0d cycles, want 1", nm, frame_start_out, n);
      end
   endtask

   // Drain one frame from the current negedge, checking every presented word and the done pulse.
   task automatic consume_frame(input string nm, input loc_t exp [N], input int hold_off, input bit toggle);
      int k = 0;
      int hs = 0;
      bit r;
      bit fin = 1'b0;
      while (!fin && k < 400) begin
         if (bus.obj_valid_out === 1'b1) begin
            checks++;
            if (hs >= int'(N) || bus.obj_idx_out !== 3'(hs) || bus.obj_loc_out !== exp[hs]) begin
               errors++;
               $display("FAIL %s word: got idx=%0d loc=%0h, want idx=%0d loc=%0h", nm,
                        bus.obj_idx_out, bus.obj_loc_out, hs, (hs < int'(N)) ? exp[hs] : 21'h0);
            end
            if (k < hold_off) r = 1'b0;
            else if (toggle) r = ((k - hold_off) % 3) == 0;
            else r = 1'b1;
            bus.obj_ready_in = r;
            if (r) hs++;
         end else begin
            checks++;
            if (frame_done_out !== 1'b1) begin
               errors++;
               $display("FAIL %s done: frame_done_out=%b with valid low, want 1", nm, frame_done_out);
            end
            fin = 1'b1;
         end
         if (!fin) begin
            @(negedge clk_in);
            k++;
         end
      end
      checks++;
      if (!fin || hs != int'(N)) begin
         errors++;
         $display("FAIL %s handshakes: got %0d finished=%0b, want %0d finished=1", nm, hs, fin, N);
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      enable_in = 1'b0;
      bus.obj_ready_in = 1'b0;
      for (int i = 0; i < int'(N); i++) obj_loc[i] = '0;
      repeat (3) @(negedge clk_in);
      checks++;
      if (bus.obj_valid_out !== 1'b0 || bus.obj_idx_out !== 3'd0 || bus.obj_loc_out !== 21'd0) begin
         errors++;
         $display("FAIL reset bus: got valid=%b idx=%0d loc=%0h, want 0 0 0",
                  bus.obj_valid_out, bus.obj_idx_out, bus.obj_loc_out);
      end
      checks++;
      if (frame_start_out !== 1'b0 || frame_done_out !== 1'b0 || busy_out !== 1'b0 || overrun_cnt_out !== 8'd0) begin
         errors++;
         $display("FAIL reset flags: got start=%b done=%b busy=%b ovr=%0d, want 0 0 0 0",
                  frame_start_out, frame_done_out, busy_out, overrun_cnt_out);
      end
   endtask

   task automatic test_basic();
      set_locs(old_locs);
      do_reset();
      bus.obj_ready_in = 1'b1;
      repeat (15) @(negedge clk_in);
      checks++;
      if (frame_start_out !== 1'b0 || busy_out !== 1'b0) begin
         errors++;
         $display("FAIL basic pre_tick: got start=%b busy=%b at cycle 15, want 0 0", frame_start_out, busy_out);
      end
      @(negedge clk_in);
      checks++;
      if (frame_start_out !== 1'b1 || busy_out !== 1'b1) begin
         errors++;
         $display("FAIL basic start: got start=%b busy=%b at cycle 16, want 1 1", frame_start_out, busy_out);
      end
      for (int i = 0; i < int'(N); i++) begin
         checks++;
         if (bus.obj_valid_out !== 1'b1 || bus.obj_idx_out !== 3'(i) || bus.obj_loc_out !== old_locs[i]) begin
            errors++;
            $display("FAIL basic word%0d: got valid=%b idx=%0d loc=%0h, want 1 %0d %0h", i,
                     bus.obj_valid_out, bus.obj_idx_out, bus.obj_loc_out, i, old_locs[i]);
         end
         @(negedge clk_in);
      end
      checks++;
      if (bus.obj_valid_out !== 1'b0 || frame_done_out !== 1'b1 || busy_out !== 1'b1) begin
         errors++;
         $display("FAIL basic done: got valid=%b done=%b busy=%b, want 0 1 1",
                  bus.obj_valid_out, frame_done_out, busy_out);
      end
      @(negedge clk_in);
      checks++;
      if (frame_done_out !== 1'b0 || busy_out !== 1'b0 || overrun_cnt_out !== 8'd0) begin
         errors++;
         $display("FAIL basic idle: got done=%b busy=%b ovr=%0d, want 0 0 0",
                  frame_done_out, busy_out, overrun_cnt_out);
      end
   endtask

   task automatic test_backpressure();
      set_locs(old_locs);
      do_reset();
      wait_start("backpressure");
      consume_frame("backpressure", old_locs, 0, 1'b1);
   endtask

   task automatic test_coherence();
      set_locs(old_locs);
      do_reset();
      wait_start("coherence");
      bus.obj_ready_in = 1'b0;
      repeat (2) @(negedge clk_in);
      set_locs(ones_locs);
      consume_frame("coherence_old", old_locs, 0, 1'b1);
      wait_start("coherence_next");
      consume_frame("coherence_new", ones_locs, 0, 1'b0);
   endtask

   task automatic test_overrun();
      bit restarted = 1'b0;
      set_locs(old_locs);
      do_reset();
      wait_start("overrun");
      bus.obj_ready_in = 1'b0;
      for (int n = 1; n < 40; n++) begin
         @(negedge clk_in);
         if (n == 3) set_locs(abc_locs);
         if (frame_start_out !== 1'b0) restarted = 1'b1;
      end
      checks++;
      if (overrun_cnt_out !== 8'd2 || restarted || bus.obj_valid_out !== 1'b1 || bus.obj_idx_out !== 3'd0) begin
         errors++;
         $display("FAIL overrun hold: got ovr=%0d restarted=%b valid=%b idx=%0d, want 2 0 1 0",
                  overrun_cnt_out, restarted, bus.obj_valid_out, bus.obj_idx_out);
      end
      consume_frame("overrun_drain", old_locs, 0, 1'b0);
      bus.obj_ready_in = 1'b0;
      repeat (300 * TP + 32) @(negedge clk_in);
      checks++;
      if (overrun_cnt_out !== 8'd255 || bus.obj_valid_out !== 1'b1 || bus.obj_idx_out !== 3'd0) begin
         errors++;
         $display("FAIL overrun saturate: got ovr=%0d valid=%b idx=%0d, want 255 1 0",
                  overrun_cnt_out, bus.obj_valid_out, bus.obj_idx_out);
      end
      consume_frame("overrun_sat_drain", abc_locs, 0, 1'b0);
   endtask

   // Last handshake lands so that DONE coincides with the tick: it must be counted, not queued.
   task automatic test_tick_in_done();
      bit early = 1'b0;
      set_locs(old_locs);
      do_reset();
      wait_start("tick_done");
      consume_frame("tick_done", old_locs, 9, 1'b0);
      @(negedge clk_in);
      checks++;
      if (overrun_cnt_out !== 8'd1 || frame_start_out !== 1'b0 || busy_out !== 1'b0) begin
         errors++;
         $display("FAIL tick_done count: got ovr=%0d start=%b busy=%b, want 1 0 0",
                  overrun_cnt_out, frame_start_out, busy_out);
      end
      repeat (15) begin
         @(negedge clk_in);
         if (frame_start_out !== 1'b0) early = 1'b1;
      end
      @(negedge clk_in);
      checks++;
      if (early || frame_start_out !== 1'b1) begin
         errors++;
         $display("FAIL tick_done next: got early=%b start=%b, want 0 1", early, frame_start_out);
      end
   endtask

   task automatic test_enable_reset();
      bit seen = 1'b0;
      bit done_seen = 1'b0;
      bit early = 1'b0;
      set_locs(old_locs);
      do_reset();
      wait_start("enable_drop");
      enable_in = 1'b0;
      consume_frame("enable_drop", old_locs, 0, 1'b0);
      repeat (60) begin
         @(negedge clk_in);
         if (frame_start_out !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen || busy_out !== 1'b0) begin
         errors++;
         $display("FAIL enable_drop idle: got extra_start=%b busy=%b, want 0 0", seen, busy_out);
      end

      do_reset();
      wait_start("reset_mid");
      bus.obj_ready_in = 1'b1;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b1;
      enable_in = 1'b0;
      #1;
      checks++;
      if (bus.obj_valid_out !== 1'b0 || bus.obj_idx_out !== 3'd0 || bus.obj_loc_out !== 21'd0 ||
          busy_out !== 1'b0 || frame_start_out !== 1'b0 || frame_done_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid async: got valid=%b idx=%0d loc=%0h busy=%b start=%b done=%b, want all 0",
                  bus.obj_valid_out, bus.obj_idx_out, bus.obj_loc_out, busy_out, frame_start_out, frame_done_out);
      end
      repeat (3) begin
         @(negedge clk_in);
         if (frame_done_out !== 1'b0) done_seen = 1'b1;
      end
      rst_in = 1'b0;
      enable_in = 1'b1;
      repeat (15) begin
         @(negedge clk_in);
         if (frame_start_out !== 1'b0 || frame_done_out !== 1'b0) early = 1'b1;
      end
      @(negedge clk_in);
      checks++;
      if (done_seen || early || frame_start_out !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid restart: got done_pulse=%b early=%b start=%b, want 0 0 1",
                  done_seen, early, frame_start_out);
      end
   endtask

   initial begin
      for (int i = 0; i < int'(N); i++) begin
         old_locs[i]  = LW'(i * 1000 + 7);
         ones_locs[i] = 21'h1FFFFF;
         abc_locs[i]  = 21'h0ABCDE;
      end
      test_reset();
      test_basic();
      test_backpressure();
      test_coherence();
      test_overrun();
      test_tick_in_done();
      test_enable_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
